// File: rtl/div_pkg.sv
// Shared types and constants for the shift-subtract divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_DW = 16;
    localparam int DIV_VW = 8;
    localparam int DIV_CW = $clog2(DIV_DW);

    // Quotient reported when the divisor is zero
    localparam logic [DIV_DW-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   r_in,
    input  logic          q_msb,
    input  logic [VW-1:0] d,
    output logic [VW:0]   r_out,
    output logic          q_bit
);

    logic [VW:0] r_sh;
    logic [VW:0] d_ext;

    // Shift the partial remainder, then subtract the divisor only if it fits
    always_comb begin
        r_sh  = {r_in[VW-1:0], q_msb};
        d_ext = {1'b0, d};
        if (r_sh >= d_ext) begin
            r_out = r_sh - d_ext;
            q_bit = 1'b1;
        end else begin
            r_out = r_sh;
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Latency: DW+1 cycles from accepted start to done (1 cycle on divide-by-zero).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          dbz,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW:0]   r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] d_q, d_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;

    logic [VW:0]   step_r;
    logic          step_bit;

    div_step #(.VW(VW)) u_step (
        .r_in  (r_q),
        .q_msb (q_q[DW-1]),
        .d     (d_q),
        .r_out (step_r),
        .q_bit (step_bit)
    );

    // Next-state and datapath: capture on start, iterate in RUN, publish on the last step
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    d_d         = divisor;
                    q_d         = dividend;
                    r_d         = '0;
                    cnt_d       = '0;
                    dbz_d       = 1'b0;
                    quotient_d  = '0;
                    remainder_d = '0;
                    if (divisor == '0) begin
                        // Nothing to iterate: report immediately
                        state_d     = DONE;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = DW'(DBZ_QUOTIENT);
                        remainder_d = '0;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = {q_q[DW-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    // Final R[VW] is always clear, so the low bits are the remainder
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = {q_q[DW-2:0], step_bit};
                    remainder_d = step_r[VW-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider against an arithmetic reference.
// Latency: checks DW+1 cycle normal latency and 1 cycle divide-by-zero latency.
// Backpressure: checks that start is ignored mid-run and accepted in the done cycle.
module tb_shift_sub_divider;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_sub_divider dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Reference model: plain integer division with the divide-by-zero convention
    function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return {1'b1, 16'hFFFF, 8'h00};
        return {1'b0, 16'(a / b), 8'(a % b)};
    endfunction

    // Step one edge and move to the sampling point just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from idle and wait (bounded) for done.
    // lat counts edges from the capturing edge (1) to the edge that raises done.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output int lat, output int busy_cnt, output logic busy_at_done);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        lat      = 0;
        busy_cnt = 0;
        busy_at_done = 1'b0;
        while (lat <= 40) begin
            tick();
            if (lat == 0) begin
                start    = 1'b0;
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
            lat++;
            if (done) begin
                busy_at_done = busy;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        tick();
        tick();
        vectors++;
        if ({busy, done, dbz, quotient, remainder} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, dbz, quotient, remainder);
        end
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] a_tab [4] = '{16'd1000, 16'hFFFF, 16'hFFFF, 16'd100};
        logic [7:0]  b_tab [4] = '{8'd7, 8'hFF, 8'd1, 8'd200};
        logic [15:0] q_tab [4] = '{16'd142, 16'd257, 16'hFFFF, 16'd0};
        logic [7:0]  r_tab [4] = '{8'd6, 8'd0, 8'd0, 8'd100};
        int lat, bc;
        logic bd;
        for (int i = 0; i < 4; i++) begin
            run_op(a_tab[i], b_tab[i], lat, bc, bd);
            vectors++;
            if (lat !== 17 || bc !== 16 || bd !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy_cycles=%0d busy_at_done=%b, want 17/16/0",
                         i, lat, bc, bd);
            end
            vectors++;
            if ({dbz, quotient, remainder} !== {1'b0, q_tab[i], r_tab[i]}) begin
                miscompares++;
                $display("FAIL directed_result[%0d]: got dbz=%b q=%0d r=%0d, want dbz=0 q=%0d r=%0d",
                         i, dbz, quotient, remainder, q_tab[i], r_tab[i]);
            end
            tick();
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL done_pulse[%0d]: got done=%b one cycle later, want 0", i, done);
            end
            for (int k = 0; k < 3; k++) tick();
            vectors++;
            if ({quotient, remainder} !== {q_tab[i], r_tab[i]}) begin
                miscompares++;
                $display("FAIL result_hold[%0d]: got q=%0d r=%0d, want q=%0d r=%0d",
                         i, quotient, remainder, q_tab[i], r_tab[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        logic bd;
        run_op(16'd5, 8'd0, lat, bc, bd);
        vectors++;
        if (lat !== 1 || bc !== 0 || bd !== 1'b0) begin
            miscompares++;
            $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d busy_at_done=%b, want 1/0/0", lat, bc, bd);
        end
        vectors++;
        if ({dbz, quotient, remainder} !== {1'b1, 16'hFFFF, 8'h00}) begin
            miscompares++;
            $display("FAIL dbz_result: got dbz=%b q=%h r=%h, want dbz=1 q=ffff r=00", dbz, quotient, remainder);
        end
        tick();
        run_op(16'd9, 8'd4, lat, bc, bd);
        vectors++;
        if ({dbz, quotient, remainder} !== {1'b0, 16'd2, 8'd1}) begin
            miscompares++;
            $display("FAIL dbz_clears: got dbz=%b q=%0d r=%0d, want dbz=0 q=2 r=1", dbz, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int cyc = 0;
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        while (cyc <= 40) begin
            tick();
            cyc++;
            start = (cyc == 4);
            dividend = (cyc == 4) ? 16'd50 : 16'($urandom);
            divisor  = (cyc == 4) ? 8'd5 : 8'($urandom);
            if (done) break;
        end
        start = 1'b0;
        vectors++;
        if (cyc !== 17 || {dbz, quotient, remainder} !== {1'b0, 16'd142, 8'd6}) begin
            miscompares++;
            $display("FAIL ignore_start: got cycle=%0d dbz=%b q=%0d r=%0d, want cycle=17 q=142 r=6",
                     cyc, dbz, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        int lat, bc;
        logic bd;
        int done_seen = 0;
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        tick();
        start = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        vectors++;
        if ({busy, done, dbz, quotient, remainder} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_midrun: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, dbz, quotient, remainder);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL reset_discard: got %0d busy/done cycles after reset, want 0", done_seen);
        end
        run_op(16'd50, 8'd5, lat, bc, bd);
        vectors++;
        if (lat !== 17 || {dbz, quotient, remainder} !== {1'b0, 16'd10, 8'd0}) begin
            miscompares++;
            $display("FAIL after_reset_op: got lat=%0d dbz=%b q=%0d r=%0d, want lat=17 q=10 r=0",
                     lat, dbz, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] a2 = 16'd54321;
        logic [7:0]  b2 = 8'd99;
        int cyc = 0;
        start = 1'b1; dividend = 16'd1234; divisor = 8'd10;
        while (cyc <= 40 && !done) begin
            tick();
            cyc++;
        end
        vectors++;
        if ({dbz, quotient, remainder} !== model(16'd1234, 8'd10)) begin
            miscompares++;
            $display("FAIL b2b_first: got q=%0d r=%0d, want q=123 r=4", quotient, remainder);
        end
        dividend = a2; divisor = b2;
        cyc = 0;
        tick();
        cyc++;
        start = 1'b0;
        while (cyc <= 40 && !done) begin
            tick();
            cyc++;
        end
        vectors++;
        if (cyc !== 17 || {dbz, quotient, remainder} !== model(a2, b2)) begin
            miscompares++;
            $display("FAIL b2b_second: got spacing=%0d q=%0d r=%0d, want spacing=17 q=%0d r=%0d",
                     cyc, quotient, remainder, a2 / b2, a2 % b2);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  b;
        logic [24:0] exp;
        int lat, bc;
        logic bd;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            exp = model(a, b);
            run_op(a, b, lat, bc, bd);
            vectors++;
            if ({dbz, quotient, remainder} !== exp || lat !== ((b == 8'd0) ? 1 : 17)) begin
                miscompares++;
                $display("FAIL random[%0d] %0d/%0d: got lat=%0d dbz=%b q=%0d r=%0d, want dbz=%b q=%0d r=%0d",
                         i, a, b, lat, dbz, quotient, remainder, exp[24], exp[23:8], exp[7:0]);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
